// File: rtl/snn_pkg.sv
// Shared packet encoding and FSM state for the SNN partial-sum accumulator.
// Field offsets are counted down from the packet MSB so any WIDTH >= header + payload works.
package snn_pkg;

  localparam int ADDR_W = 4;
  localparam int TYPE_W = 2;
  localparam int HDR_W  = 2 * ADDR_W + TYPE_W;

  localparam int SRC_OFS  = 0;
  localparam int DST_OFS  = ADDR_W;
  localparam int TYPE_OFS = 2 * ADDR_W;

  localparam logic [TYPE_W-1:0] PKT_PSUM  = 2'b00;
  localparam logic [TYPE_W-1:0] PKT_DONE  = 2'b01;
  localparam logic [TYPE_W-1:0] PKT_MEMB  = 2'b10;
  localparam logic [TYPE_W-1:0] PKT_SPIKE = 2'b11;

  localparam logic [3:0] DONE_CODE = 4'hF;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_COMPUTE,
    ST_SEND_POT,
    ST_SEND_SPIKE,
    ST_ADVANCE,
    ST_SEND_DONE
  } state_t;

endpackage

// File: rtl/psum_sat_adder.sv
// Combinational sum of NUM_PE partial sums plus optional stored potential, saturated to MP_W bits,
// then thresholded; new_pot is the post-spike potential (subtract or reset per RESET_MODE).
module psum_sat_adder #(
  parameter int NUM_PE     = 5,
  parameter int MP_W       = 13,
  parameter int THRESHOLD  = 16,
  parameter bit RESET_MODE = 1'b0
) (
  input  logic [NUM_PE-1:0][MP_W-1:0] slots,
  input  logic [MP_W-1:0]             mem_pot,
  input  logic                        use_mem,
  output logic                        spike,
  output logic [MP_W-1:0]             new_pot
);

  // Four guard bits cover up to 16 full-scale operands without wrap.
  localparam int SUM_W = MP_W + 4;
  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'((1 << MP_W) - 1);

  logic [SUM_W-1:0] sum;
  logic [MP_W-1:0]  sat;

  always_comb begin
    sum = use_mem ? SUM_W'(mem_pot) : '0;
    for (int i = 0; i < NUM_PE; i++) begin
      sum = sum + SUM_W'(slots[i]);
    end
    sat   = (sum > SAT_MAX) ? '1 : sum[MP_W-1:0];
    spike = (SUM_W'(sat) >= SUM_W'(THRESHOLD));
    if (!spike) begin
      new_pot = sat;
    end else if (RESET_MODE) begin
      new_pot = '0;
    end else begin
      new_pot = sat - MP_W'(THRESHOLD);
    end
  end

endmodule

// File: rtl/partial_sum_accum.sv
// Gathers per-PE partial sums (+ stored potential after step 0) for one neuron, then emits membrane,
// spike and done packets; out_valid 2 cycles after the last input, each packet held until out_ready.
module partial_sum_accum
  import snn_pkg::*;
#(
  parameter int         WIDTH        = 64,
  parameter int         NUM_PE       = 5,
  parameter logic [3:0] PE_ADDR_BASE = 4'h0,
  parameter int         MP_W         = 13,
  parameter int         THRESHOLD    = 16,
  parameter bit         RESET_MODE   = 1'b0,
  parameter int         NUM_NEURONS  = 5,
  parameter int         NUM_STEPS    = 8,
  parameter logic [2:0] ADDER_NUM    = 3'd0,
  parameter bit         IS_LAST      = 1'b0,
  parameter logic [3:0] ADDER_ADDR   = 4'h6,
  parameter logic [3:0] MEM_ADDR     = 4'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err
);

  localparam int PAY_W = WIDTH - HDR_W;
  localparam int NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int SW    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  state_t                      state;
  logic [NW-1:0]               neuron;
  logic [SW-1:0]               step;
  logic [NUM_PE-1:0]           pe_bits;
  logic                        mem_bit;
  logic [NUM_PE-1:0][MP_W-1:0] slots;
  logic [MP_W-1:0]             mem_pot;
  logic                        spike_q;

  logic [ADDR_W-1:0] src;
  logic [TYPE_W-1:0] ptype;
  logic [MP_W-1:0]   pay_val;
  logic              unused_in;

  assign src       = in_data[WIDTH-1-SRC_OFS -: ADDR_W];
  assign ptype     = in_data[WIDTH-1-TYPE_OFS -: TYPE_W];
  assign pay_val   = in_data[MP_W-1:0];
  assign unused_in = ^{in_data[WIDTH-1-DST_OFS -: ADDR_W], in_data[PAY_W-1:MP_W]};

  logic              in_fire;
  logic              need_mem;
  logic [5:0]        src_off;
  logic              is_pe;
  logic [NUM_PE-1:0] pe_onehot;
  logic              psum_ok;
  logic              mem_ok;
  logic              drop;
  logic [NUM_PE-1:0] pe_bits_nxt;
  logic              mem_bit_nxt;
  logic              complete;
  logic              complete_nxt;

  always_comb begin
    in_fire   = in_valid && in_ready && (state == ST_COLLECT);
    need_mem  = (step != '0);
    src_off   = {2'b00, src} - {2'b00, PE_ADDR_BASE};
    is_pe     = (ptype == PKT_PSUM) && (src >= PE_ADDR_BASE) && (src_off < 6'(NUM_PE));
    pe_onehot = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (src_off == 6'(i)) pe_onehot[i] = is_pe;
    end
    // A repeat from an already-filled slot is dropped rather than overwriting.
    psum_ok = in_fire && is_pe && ((pe_bits & pe_onehot) == '0);
    mem_ok  = in_fire && (ptype == PKT_MEMB) && (src == MEM_ADDR) && need_mem && !mem_bit;
    drop    = in_fire && !psum_ok && !mem_ok;

    pe_bits_nxt  = pe_bits | (psum_ok ? pe_onehot : '0);
    mem_bit_nxt  = mem_bit | mem_ok;
    complete     = (&pe_bits) && (mem_bit || !need_mem);
    complete_nxt = (&pe_bits_nxt) && (mem_bit_nxt || !need_mem);
  end

  logic            add_spike;
  logic [MP_W-1:0] add_pot;

  psum_sat_adder #(
    .NUM_PE     (NUM_PE),
    .MP_W       (MP_W),
    .THRESHOLD  (THRESHOLD),
    .RESET_MODE (RESET_MODE)
  ) u_adder (
    .slots   (slots),
    .mem_pot (mem_pot),
    .use_mem (need_mem),
    .spike   (add_spike),
    .new_pot (add_pot)
  );

  function automatic logic [WIDTH-1:0] mk_pkt(input logic [TYPE_W-1:0] t,
                                              input logic [PAY_W-1:0]  pay);
    return {ADDER_ADDR, MEM_ADDR, t, pay};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_COLLECT;
      neuron    <= '0;
      step      <= '0;
      pe_bits   <= '0;
      mem_bit   <= 1'b0;
      slots     <= '0;
      mem_pot   <= '0;
      spike_q   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (complete) begin
            in_ready <= 1'b0;
            state    <= ST_COMPUTE;
          end else begin
            // Drop ready on the completing packet so nothing lands during COMPUTE.
            in_ready <= !complete_nxt;
            pe_bits  <= pe_bits_nxt;
            mem_bit  <= mem_bit_nxt;
            if (drop) err <= 1'b1;
            if (mem_ok) mem_pot <= pay_val;
            for (int i = 0; i < NUM_PE; i++) begin
              if (psum_ok && pe_onehot[i]) slots[i] <= pay_val;
            end
          end
        end

        ST_COMPUTE: begin
          spike_q   <= add_spike;
          out_valid <= 1'b1;
          out_data  <= mk_pkt(PKT_MEMB, PAY_W'(add_pot));
          state     <= ST_SEND_POT;
        end

        ST_SEND_POT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= spike_q ? ST_SEND_SPIKE : ST_ADVANCE;
          end
        end

        ST_SEND_SPIKE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= mk_pkt(PKT_SPIKE, PAY_W'({neuron, ADDER_NUM}));
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ADVANCE;
          end
        end

        ST_ADVANCE: begin
          pe_bits <= '0;
          mem_bit <= 1'b0;
          if (neuron == NW'(NUM_NEURONS - 1)) begin
            neuron   <= '0;
            step     <= (step == SW'(NUM_STEPS - 1)) ? '0 : step + 1'b1;
            in_ready <= !IS_LAST;
            state    <= IS_LAST ? ST_SEND_DONE : ST_COLLECT;
          end else begin
            neuron   <= neuron + 1'b1;
            in_ready <= 1'b1;
            state    <= ST_COLLECT;
          end
        end

        ST_SEND_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= mk_pkt(PKT_DONE, PAY_W'(DONE_CODE));
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_COLLECT;
          end
        end

        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_partial_sum_accum.sv
// Drives three accumulator configurations with directed and randomized neuron traffic and
// compares every emitted packet against an arithmetic model of integrate/saturate/threshold.
module tb_partial_sum_accum;

  logic        clk;
  logic [2:0]  rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [63:0] in_data, od0, od1, od2;

  int checks = 0;
  int errors = 0;
  int vals[5];
  int ord[6];
  int memA[5];
  int memC[2];
  int pot;
  int lat;

  // A: defaults. B: reset-to-zero mode, adder index 5. C: last adder, 2 neurons, 2 steps.
  partial_sum_accum dut_a (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0), .err(err[0]));

  partial_sum_accum #(.RESET_MODE(1'b1), .ADDER_NUM(3'd5)) dut_b (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1), .err(err[1]));

  partial_sum_accum #(.IS_LAST(1'b1), .NUM_NEURONS(2), .NUM_STEPS(2)) dut_c (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2), .err(err[2]));

  always #5 clk = ~clk;

  function automatic logic [63:0] od(input int d);
    case (d)
      0:       return od0;
      1:       return od1;
      default: return od2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: total of accepted values, clamp to 13 bits, threshold 16.
  function automatic void model(input int total, input int mem, input bit rmode,
                                output int p, output bit spk);
    int t;
    t = total + mem;
    if (t > 8191) t = 8191;
    spk = (t >= 16);
    p = spk ? (rmode ? 0 : t - 16) : t;
  endfunction

  task automatic send(input int d, input logic [1:0] t, input logic [3:0] s, input logic [12:0] v);
    int n;
    n = 0;
    @(negedge clk);
    in_data = {s, 4'h6, t, 41'd0, v};
    in_valid[d] = 1'b1;
    while (!in_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("send_ready", in_ready[d], 1'b1);
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
  endtask

  task automatic recv(input int d, input logic [1:0] t, input logic [53:0] pay, input string tag,
                      input int hold, output int latency);
    logic [63:0] exp;
    int n;
    exp = {4'h6, 4'h0, t, pay};
    n = 0;
    @(negedge clk);
    while (!out_valid[d] && n < 200) begin
      n++;
      @(negedge clk);
    end
    latency = n;
    chk1({tag, "_valid"}, out_valid[d], 1'b1);
    chk({tag, "_data"}, od(d), exp);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_data"}, od(d), exp);
      chk1({tag, "_hold_inrdy"}, in_ready[d], 1'b0);
    end
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1 out_ready[d] = 1'b0;
    @(negedge clk);
    chk1({tag, "_drop"}, out_valid[d], 1'b0);
  endtask

  task automatic idle(input int d, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      chk1("idle_valid", out_valid[d], 1'b0);
    end
  endtask

  task automatic rand_vals(input int hi);
    for (int i = 0; i < 5; i++) vals[i] = int'($urandom_range(hi, 0));
  endtask

  task automatic do_neuron(input int d, input int nrn, input bit with_mem, input int memv,
                           input bit rmode, input int anum, input bit shuffle, input int hold,
                           input bit exp_done, output int p);
    int tot, cnt, j, tmp, l;
    bit spk;
    tot = 0;
    for (int i = 0; i < 5; i++) tot += vals[i];
    model(tot, with_mem ? memv : 0, rmode, p, spk);
    cnt = with_mem ? 6 : 5;
    if (shuffle) begin
      for (int i = 0; i < 6; i++) ord[i] = i;
      for (int i = cnt - 1; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
    end
    for (int i = 0; i < cnt; i++) begin
      if (ord[i] == 5) send(d, 2'b10, 4'h0, 13'(memv));
      else send(d, 2'b00, 4'(ord[i]), 13'(vals[ord[i]]));
    end
    recv(d, 2'b10, 54'(p), "membrane", hold, l);
    if (hold == 0) chk("latency", 64'(l), 64'd2);
    if (spk) recv(d, 2'b11, 54'((nrn << 3) | anum), "spike", 0, l);
    if (exp_done) recv(d, 2'b01, 54'hF, "done", 0, l);
    if (!spk && !exp_done) idle(d, 3);
  endtask

  task automatic pulse_rst(input int d);
    #2 rst[d] = 1'b1;
    #1;
    chk1("arst_out_valid", out_valid[d], 1'b0);
    chk("arst_out_data", od(d), 64'd0);
    chk1("arst_in_ready", in_ready[d], 1'b0);
    chk1("arst_err", err[d], 1'b0);
    @(negedge clk);
    rst[d] = 1'b0;
    chk1("arst_ready_before_edge", in_ready[d], 1'b0);
    @(posedge clk);
    #1 chk1("arst_ready_after_edge", in_ready[d], 1'b1);
  endtask

  initial begin
    clk = 1'b0;
    rst = '1;
    in_valid = '0;
    out_ready = '0;
    in_data = '0;
    #12;
    for (int d = 0; d < 3; d++) begin
      chk1("reset_out_valid", out_valid[d], 1'b0);
      chk("reset_out_data", od(d), 64'd0);
      chk1("reset_in_ready", in_ready[d], 1'b0);
      chk1("reset_err", err[d], 1'b0);
    end
    @(negedge clk);
    rst = '0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk1("ready_after_reset", in_ready[d], 1'b1);

    // ---- A, step 0 ----
    vals = '{1, 2, 3, 4, 5};
    ord  = '{4, 0, 2, 1, 3, 5};
    do_neuron(0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, pot);
    memA[0] = pot;

    vals = '{5, 5, 5, 5, 5};
    do_neuron(0, 1, 1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0, pot);
    memA[1] = pot;

    // Duplicate PE2 and out-of-range source are dropped; sum uses first PE2 value.
    send(0, 2'b00, 4'h0, 13'd1);
    send(0, 2'b00, 4'h1, 13'd1);
    send(0, 2'b00, 4'h2, 13'd7);
    chk1("err_before_drop", err[0], 1'b0);
    send(0, 2'b00, 4'h2, 13'd50);
    send(0, 2'b00, 4'h7, 13'd99);
    chk1("err_after_drop", err[0], 1'b1);
    send(0, 2'b00, 4'h3, 13'd1);
    send(0, 2'b00, 4'h4, 13'd1);
    recv(0, 2'b10, 54'd11, "drop_membrane", 0, lat);
    idle(0, 3);
    memA[2] = 11;

    rand_vals(20);
    do_neuron(0, 3, 1'b0, 0, 1'b0, 0, 1'b1, 10, 1'b0, pot);
    memA[3] = pot;
    rand_vals(20);
    do_neuron(0, 4, 1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0, pot);
    memA[4] = pot;

    // ---- A, step 1: saturation, then stored potentials ----
    vals = '{100, 100, 100, 100, 100};
    do_neuron(0, 0, 1'b1, 8191, 1'b0, 0, 1'b1, 0, 1'b0, pot);
    memA[0] = pot;
    for (int n = 1; n < 5; n++) begin
      rand_vals(40);
      do_neuron(0, n, 1'b1, memA[n], 1'b0, 0, 1'b1, 0, 1'b0, pot);
      memA[n] = pot;
    end
    chk1("err_sticky", err[0], 1'b1);

    // ---- B: reset mode, stray membrane in step 0, async resets ----
    vals = '{5, 5, 5, 5, 5};
    do_neuron(1, 0, 1'b0, 0, 1'b1, 5, 1'b1, 0, 1'b0, pot);
    chk1("b_err_clean", err[1], 1'b0);
    send(1, 2'b10, 4'h0, 13'd1000);
    chk1("b_err_membrane_step0", err[1], 1'b1);
    rand_vals(10);
    do_neuron(1, 1, 1'b0, 0, 1'b1, 5, 1'b1, 0, 1'b0, pot);

    send(1, 2'b00, 4'h0, 13'd100);
    send(1, 2'b00, 4'h1, 13'd100);
    send(1, 2'b00, 4'h2, 13'd100);
    pulse_rst(1);
    rand_vals(8);
    do_neuron(1, 0, 1'b0, 0, 1'b1, 5, 1'b1, 0, 1'b0, pot);

    for (int i = 0; i < 5; i++) send(1, 2'b00, 4'(i), 13'd10);
    repeat (3) @(negedge clk);
    chk1("b_pending_valid", out_valid[1], 1'b1);
    pulse_rst(1);
    vals = '{3, 3, 3, 3, 5};
    do_neuron(1, 0, 1'b0, 0, 1'b1, 5, 1'b1, 0, 1'b0, pot);

    // ---- C: done packets and step wrap over two inferences ----
    for (int inf = 0; inf < 2; inf++) begin
      for (int s = 0; s < 2; s++) begin
        for (int n = 0; n < 2; n++) begin
          rand_vals(12);
          do_neuron(2, n, s != 0, memC[n], 1'b0, 0, 1'b1, 0, n == 1, pot);
          memC[n] = pot;
        end
      end
    end
    chk1("c_err_clean", err[2], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
